// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the sequential N x N multiplier
package mul_seq_pkg;

    localparam int MUL_N = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    // Partial-product shift, in half-operand units: LL=0, LH=1, HL=1, HH=2
    localparam int PP_SHIFT_HALVES [4] = '{0, 1, 1, 2};

    function automatic int pp_shift(input int n, input logic [1:0] k);
        return (n / 2) * PP_SHIFT_HALVES[k];
    endfunction

endpackage

// File: rtl/unsigned_mul.sv
// rtl/unsigned_mul.sv - W x W unsigned multiplier with a registered product
module unsigned_mul #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [W-1:0]   M,
    input  logic [W-1:0]   Q,
    output logic [2*W-1:0] R
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            R <= '0;
        end else begin
            R <= {{W{1'b0}}, M} * {{W{1'b0}}, Q};
        end
    end

endmodule

// File: rtl/mul6_seq_ctrl.sv
// rtl/mul6_seq_ctrl.sv - N x N multiplier built from one shared N/2 x N/2 registered multiplier
module mul6_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   Q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] R,
    output logic           busy
);

    localparam int H = N / 2;

    state_t         state;
    logic [1:0]     idx;
    logic [N-1:0]   m_reg;
    logic [N-1:0]   q_reg;
    logic [2*N-1:0] acc;

    logic [H-1:0]   mul_a;
    logic [H-1:0]   mul_b;
    logic [N-1:0]   pp;
    logic [1:0]     add_sel;
    logic [2*N-1:0] acc_next;
    logic           accept;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    // idx bit 1 picks the M half, bit 0 picks the Q half
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == MUL) begin
            mul_a = idx[1] ? m_reg[N-1:H] : m_reg[H-1:0];
            mul_b = idx[0] ? q_reg[N-1:H] : q_reg[H-1:0];
        end
    end

    // The product arriving now was issued one cycle earlier
    always_comb begin
        add_sel  = (state == LAST) ? 2'd3 : idx - 2'd1;
        acc_next = acc + ({{N{1'b0}}, pp} << pp_shift(N, add_sel));
    end

    unsigned_mul #(.W(H)) u_mul (
        .clk  (clk),
        .rstn (rstn),
        .M    (mul_a),
        .Q    (mul_b),
        .R    (pp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            idx       <= 2'd0;
            m_reg     <= '0;
            q_reg     <= '0;
            acc       <= '0;
            R         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_reg <= M;
                        q_reg <= Q;
                        acc   <= '0;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (idx != 2'd0) begin
                        acc <= acc_next;
                    end
                    if (idx == 2'd3) begin
                        state <= LAST;
                    end
                    idx <= idx + 2'd1;
                end
                LAST: begin
                    acc       <= acc_next;
                    R         <= acc_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (accept) begin
                        m_reg     <= M;
                        q_reg     <= Q;
                        acc       <= '0;
                        idx       <= 2'd0;
                        out_valid <= 1'b0;
                        state     <= MUL;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul6_seq_ctrl.md
MUL6_SEQ_CTRL -- requirements
Module: mul6_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 6, operand width; N SHALL be even.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL be rising-edge clocked.
REQ-003 SHALL have port rstn, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, operands accepted this cycle when in_valid is also high.
REQ-006 SHALL have port M, input, N, unsigned multiplicand.
REQ-007 SHALL have port Q, input, N, unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1, R holds a finished product.
REQ-009 SHALL have port out_ready, input, 1, consumer takes R when out_valid is high.
REQ-010 SHALL have port R, output, 2N, unsigned product M*Q.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL time-share one N/2 x N/2 multiplier (registered output, 1-cycle latency) across four partial products instead of using four instances.
REQ-013 SHALL latch M and Q and clear the 2N-bit accumulator on accept, where accept = in_valid && in_ready.
REQ-014 SHALL use FSM states IDLE, MUL, LAST and DONE.
REQ-015 FSM transitions SHALL be: IDLE->MUL on accept; MUL->LAST after 4 cycles (idx 0..3); LAST->DONE after 1 cycle; DONE->IDLE on out_ready unless a new accept occurs, in which case DONE->MUL.
REQ-016 In MUL, idx SHALL select: 0 = Ml*Ql, shift 0; 1 = Ml*Qh, shift N/2; 2 = Mh*Ql, shift N/2; 3 = Mh*Qh, shift N. Ml/Mh and Ql/Qh are the low/high N/2 bits.
REQ-017 Each sub-multiplier result SHALL be added (shifted per REQ-016) into the accumulator in the cycle after it is issued: pp0..pp2 during MUL idx 1..3, pp3 during LAST.
REQ-018 Accumulator additions SHALL be 2N bits wide, never overflow, and use no truncation other than the 2N-bit output.
REQ-019 out_valid SHALL rise exactly 5 clock edges after the accept edge and SHALL equal (state==DONE).
REQ-020 R SHALL equal the accumulator and remain stable from out_valid rising until the cycle after the out_ready handshake; after that it holds its value until the next accumulation begins.
REQ-021 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), giving a 6-cycle initiation interval with out_ready held high.
REQ-022 in_valid SHALL be ignored in MUL and LAST; M and Q changes there SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored when out_valid is low.
REQ-024 Sub-multiplier inputs SHALL be driven to 0 outside MUL.

Reset
REQ-025 rstn low SHALL asynchronously force: state IDLE, idx 0, operand registers 0, accumulator 0, R 0, out_valid 0, busy 0, and the sub-multiplier output 0.
REQ-026 Reset mid-operation SHALL abandon the product with no out_valid pulse; in_ready SHALL be high on the first cycle after rstn deasserts.

Structure
REQ-027 The shared package mul_seq_pkg SHALL hold the state enum (IDLE, MUL, LAST, DONE), the default N, and the partial-product shift constants.
REQ-028 SHALL instantiate exactly one existing unsigned_mul (clk, rstn, M, Q, R) as its sub-module.
REQ-029 Implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-030 Bench SHALL cover: M=45, Q=27, out_ready=1 -> out_valid 5 edges after accept, R=12'h4BF (1215).
REQ-031 Bench SHALL cover: M=63, Q=63 -> R=12'hF81; and M=0, Q=63 -> R=0.
REQ-032 Bench SHALL cover: M=7, Q=56, out_ready low for 10 cycles -> out_valid stays high, R=12'h188 stable, in_ready low, busy high throughout.
REQ-033 Bench SHALL cover: back-to-back pairs (45,27) then (63,63) with in_valid and out_ready held high -> second accept in the DONE cycle of the first, results 1215 and 3969, 6-cycle spacing.
REQ-034 Bench SHALL cover: rstn pulsed low during MUL idx 2 -> no out_valid, all outputs 0; a new pair (5,3) then yields R=15.
REQ-035 Bench SHALL cover: 1000 random pairs, including M/Q toggling during MUL -> R==M*Q of the accepted pair for every handshake.
